// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer. Issues one request at a time to instruction
// memory at the current PC, waits for the response (any latency >= 1 cycle,
// a 1-cycle memory answers in the same cycle the request is raised), and
// delivers the instruction to the IF/ID boundary. Decode stalls are absorbed
// by a one-entry buffer. Redirects squash the in-flight or buffered
// instruction; a redirect that lands while a request is outstanding is parked
// until the stale response drains.
//
// Ports
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_pc                 current PC from the PC register
//   i_stall              decode stall, no delivery allowed this cycle
//   i_redirect(_pc)      taken branch/jump and its target
//   o_imem_req/addr      fetch request and address (address == i_pc)
//   i_imem_valid/rdata   one-cycle response pulse and instruction word
//   o_if_en, o_next_pc   PC register load enable and load value
//   o_inst_valid/inst/   registered instruction handed to decode; o_inst is
//   o_inst_pc            a NOP whenever o_inst_valid is low
//   o_fetch_cnt          instructions delivered since reset (wraps)
// ---------------------------------------------------------------------------
module fetch_ctrl (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_valid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_if_en,
   output logic [31:0] o_next_pc,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic [31:0] o_fetch_cnt
);

   localparam logic [31:0] NOP_INST = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         pend_pc_q    <= 32'd0;
         buf_inst_q   <= 32'd0;
         buf_pc_q     <= 32'd0;
         inst_valid_q <= 1'b0;
         inst_q       <= NOP_INST;
         inst_pc_q    <= 32'd0;
         fetch_cnt_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         pend_pc_q    <= pend_pc_d;
         buf_inst_q   <= buf_inst_d;
         buf_pc_q     <= buf_pc_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, PC control and delivery
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      pend_pc_d    = pend_pc_q;
      buf_inst_d   = buf_inst_q;
      buf_pc_d     = buf_pc_q;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      inst_pc_d    = inst_pc_q;
      fetch_cnt_d  = fetch_cnt_q;
      o_if_en      = 1'b0;
      o_next_pc    = i_pc + 32'd4;

      case (state_q)
         IDLE: begin
            // Any response seen here belongs to an abandoned request.
            state_d = FETCH;
         end

         FETCH: begin
            if (!i_imem_valid) begin
               // The PC must not move while the request is outstanding, so a
               // redirect is parked and applied once the response drains.
               if (i_redirect) begin
                  pend_pc_d = i_redirect_pc;
                  state_d   = DRAIN;
               end
            end else if (i_redirect) begin
               // Response is on the wrong path: drop it, steer the PC.
               o_if_en   = 1'b1;
               o_next_pc = i_redirect_pc;
            end else if (i_stall) begin
               // Keep the PC put; the buffered copy is delivered from HOLD.
               buf_inst_d = i_imem_rdata;
               buf_pc_d   = i_pc;
               state_d    = HOLD;
            end else begin
               inst_valid_d = 1'b1;
               inst_d       = i_imem_rdata;
               inst_pc_d    = i_pc;
               fetch_cnt_d  = fetch_cnt_q + 32'd1;
               o_if_en      = 1'b1;
            end
         end

         DRAIN: begin
            if (i_redirect) begin
               pend_pc_d = i_redirect_pc;
            end
            if (i_imem_valid) begin
               // A redirect in the draining cycle is newer than pend_pc.
               o_if_en   = 1'b1;
               o_next_pc = i_redirect ? i_redirect_pc : pend_pc_q;
               state_d   = FETCH;
            end
         end

         HOLD: begin
            if (i_redirect) begin
               o_if_en   = 1'b1;
               o_next_pc = i_redirect_pc;
               state_d   = FETCH;
            end else if (!i_stall) begin
               inst_valid_d = 1'b1;
               inst_d       = buf_inst_q;
               inst_pc_d    = buf_pc_q;
               fetch_cnt_d  = fetch_cnt_q + 32'd1;
               o_if_en      = 1'b1;
               o_next_pc    = buf_pc_q + 32'd4;
               state_d      = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_imem_req   = (state_q == FETCH) || (state_q == DRAIN);
   assign o_imem_addr  = i_pc;
   assign o_inst_valid = inst_valid_q;
   assign o_inst       = inst_q;
   assign o_inst_pc    = inst_pc_q;
   assign o_fetch_cnt  = fetch_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage. It drives the PC register's enable and next-PC value, runs a request/valid handshake to instruction memory with any response latency of one cycle or more, and delivers fetched instructions to the IF/ID boundary. It also handles decode stalls and branch/jump redirects, including a redirect that arrives while a fetch is still in flight. It sits between the PC register, instruction memory, and the EX-stage redirect and hazard logic.

## Interface
- NOP_INST, 32'h00000013, value driven on o_inst when no instruction is valid
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high; clock i_clk
- i_pc  in  32  current PC from the PC register
- i_stall  in  1  downstream (load-use) stall; no new instruction may be delivered
- i_redirect  in  1  taken branch/jump this cycle
- i_redirect_pc  in  32  redirect target
- o_imem_req  out  1  fetch request
- o_imem_addr  out  32  fetch address; equals i_pc
- i_imem_valid  in  1  response valid, one-cycle pulse
- i_imem_rdata  in  32  response instruction
- o_if_en  out  1  PC register load enable
- o_next_pc  out  32  value the PC register loads when o_if_en=1
- o_inst_valid  out  1  registered: o_inst/o_inst_pc hold a live instruction this cycle
- o_inst  out  32  registered instruction
- o_inst_pc  out  32  registered PC of o_inst
- o_fetch_cnt  out  32  instructions delivered since reset; wraps at 2^32

## Operation
- States:
  - IDLE: post-reset, one cycle.
  - FETCH: request outstanding.
  - DRAIN: request outstanding, result to be discarded, redirect pending.
  - HOLD: instruction buffered, waiting for the stall to clear.
- Registers:
  - state
  - pend_pc[31:0]: saved redirect target
  - buf_inst[31:0]: buffered instruction
  - buf_pc[31:0]: PC of buffered instruction
- o_imem_req=1 in FETCH and DRAIN, 0 otherwise. The memory address is held stable until valid, so the PC never changes while a request is outstanding.
- Default each cycle: o_if_en=0, o_next_pc=i_pc+4 (mod 2^32), and o_inst_valid=0 on the next clock.
- IDLE: go to FETCH.
- FETCH, no valid:
  - i_redirect=1: pend_pc<=i_redirect_pc, go to DRAIN.
  - Otherwise stay in FETCH.
- FETCH, valid, priority order:
  - i_redirect=1: discard the response; o_if_en=1, o_next_pc=i_redirect_pc; stay in FETCH.
  - i_stall=1: buf_inst<=rdata, buf_pc<=i_pc; go to HOLD.
  - Otherwise deliver: o_inst<=rdata, o_inst_pc<=i_pc, o_inst_valid<=1, o_fetch_cnt++; o_if_en=1, o_next_pc=i_pc+4; stay in FETCH.
- DRAIN:
  - A new i_redirect overwrites pend_pc.
  - On valid, discard the response. o_if_en=1, o_next_pc is i_redirect_pc if i_redirect=1 that cycle, else pend_pc. Go to FETCH.
- HOLD:
  - i_imem_valid is ignored.
  - i_redirect=1 (priority over stall): drop the buffer; o_if_en=1, o_next_pc=i_redirect_pc; go to FETCH.
  - Else if i_stall=0: deliver buf_inst/buf_pc as in FETCH; o_if_en=1, o_next_pc=buf_pc+4; go to FETCH.
- When o_inst_valid=0, o_inst is NOP_INST. o_inst_pc keeps its last value.
- Redirect beats stall in every state. A squashed instruction never asserts o_inst_valid and never increments o_fetch_cnt.

## Timing
- o_imem_req, o_imem_addr, o_if_en and o_next_pc are combinational from state and inputs.
- o_inst*, o_fetch_cnt and all internal registers update on the rising edge of i_clk.
- Reset values:
  - state IDLE
  - o_inst_valid 0
  - o_inst NOP_INST
  - o_inst_pc 0
  - o_fetch_cnt 0
  - pend_pc, buf_inst, buf_pc 0
  - o_imem_req 0 and o_if_en 0 while in IDLE
- The first request is asserted in the cycle after reset deasserts.
- Throughput with 1-cycle memory: one instruction per cycle. Latency from valid to o_inst_valid is one clock.
- Memory contract: valid never precedes req by the same cycle and never arrives for an unissued request. The memory is reset together with this block.
- Reset mid-operation: state returns to IDLE and the outstanding request is abandoned. Any valid seen in IDLE is ignored.
- o_fetch_cnt wraps from 32'hFFFFFFFF to 0.

## Test plan
- Reset, i_pc=0, 1-cycle memory, no stall → req rises 1 cycle after reset; delivered o_inst_pc values are 0, 4, 8 on consecutive cycles; o_fetch_cnt=3.
- 3-cycle memory latency → req held with address 0 for 3 cycles; o_if_en=0 until valid; exactly one delivery per response.
- Valid arrives while i_stall=1 for 2 cycles → HOLD; o_if_en=0, no delivery; on the cycle i_stall falls, o_inst is delivered with o_next_pc=buf_pc+4.
- i_redirect=1 to 32'h100 one cycle before a 3-cycle response arrives → DRAIN; response discarded (o_inst_valid stays 0); o_next_pc=32'h100; next delivered o_inst_pc=32'h100; o_fetch_cnt unchanged by the squash.
- i_redirect and i_stall both high with valid, target 32'h40 → no buffering, o_if_en=1, o_next_pc=32'h40. Second redirect to 32'h80 during DRAIN → 32'h80 wins.
- Assert i_rst during FETCH, then deliver a stale valid while in IDLE → ignored. o_fetch_cnt=0, o_inst=32'h00000013, o_inst_valid=0.
